zmips_regfile_sb: RTL and testbench
===================================

// Module: zmips_regfile_sb
// PURPOSE
//  Parametrised successor to the zmips register file. Provides 2 async read ports and
//  2 sync write ports (ALU, load). Adds optional write-to-read bypass, a per-register
//  scoreboard (busy bits) for outstanding loads, and a hardware clear sequencer after reset.
//  Sits in decode: read data feeds the operand muxes; busy bits feed the stall logic.
// PARAMETERS
//  DATA_W          32  register width in bits
//  ADDR_W           5  register address width; NREGS = 2**ADDR_W
//  BYPASS           1  1: a read returns same-cycle write data; 0: returns the stored value
//  CLEAR_ON_RESET   1  1: zero all GPRs after reset, one per cycle; 0: skip the clear
// PORTS
//  clk         in   1       clock; all state updates on rising edge
//  rst_n       in   1       async active-low reset
//  addr_0      in   ADDR_W  read port 0 address
//  addr_1      in   ADDR_W  read port 1 address
//  data_0      out  DATA_W  read port 0 data (combinational)
//  data_1      out  DATA_W  read port 1 data (combinational)
//  busy_0      out  1       scoreboard bit for addr_0 (combinational)
//  busy_1      out  1       scoreboard bit for addr_1 (combinational)
//  wr0         in   1       write enable, port 0 (ALU)
//  wr0_addr    in   ADDR_W  write address, port 0
//  wr0_data    in   DATA_W  write data, port 0
//  wr1         in   1       write enable, port 1 (load); also clears busy[wr1_addr]
//  wr1_addr    in   ADDR_W  write address, port 1
//  wr1_data    in   DATA_W  write data, port 1
//  sb_set      in   1       mark sb_addr busy (load issued)
//  sb_addr     in   ADDR_W  scoreboard set address
//  pc_val      in   DATA_W  current PC; readable at address NREGS-1
//  pc_wr       in   1       capture pc_val into the link register (address NREGS-2)
//  ready       out  1       1 = clear done; writes and scoreboard are accepted
// BEHAVIOUR
//  Map: GPRs 0..NREGS-3. NREGS-2 = link register. NREGS-1 = pc_val (read-only, live).
//  Reset (async): FSM->CLEAR (or RUN if CLEAR_ON_RESET=0), clr_idx=0, ready=0,
//    link=0, all busy=0. GPR contents are not reset directly.
//  FSM CLEAR: each cycle write 0 to GPR[clr_idx], clr_idx++. When clr_idx==NREGS-3 is
//    written -> RUN next cycle; takes NREGS-2 cycles. ready=1 only in RUN (registered).
//  In CLEAR: wr0/wr1/sb_set ignored; pc_wr still honoured; GPR reads return 0;
//    busy_x = 0. Reset asserted mid-clear restarts the clear at clr_idx=0.
//  Writes (RUN): GPR[wrN_addr] <= wrN_data on the edge. Addresses >= NREGS-2 ignored.
//    Both ports on the same address in one cycle: port 1 wins.
//  Link: pc_wr -> link <= pc_val in any state. No other write path reaches link.
//  Read: addr==NREGS-1 -> pc_val; addr==NREGS-2 -> link; else GPR (or bypass).
//  Bypass (BYPASS=1, RUN): if wr1 && wr1_addr==addr and addr is a GPR -> wr1_data;
//    else if wr0 && wr0_addr==addr -> wr0_data; else stored value. No bypass on link.
//  Scoreboard (RUN): sb_set -> busy[sb_addr]<=1; wr1 -> busy[wr1_addr]<=0.
//    Same address set and clear in one cycle: set wins. wr0 does not affect busy.
//    sb_set to address >= NREGS-2 is ignored. busy_x is 0 for special addresses.
//    busy_x reflects the registered state (no bypass of same-cycle set/clear).
// TESTING
//  T1 reset: rst_n low 3 cyc, release -> ready=0 for 30 cycles, =1 on cycle 31;
//     then read r0..r29 -> all 0x00000000; busy_0/1=0.
//  T2 write/bypass: wr0 r5=0xDEADBEEF, addr_0=5 same cycle -> data_0=0xDEADBEEF
//     (BYPASS=0 build: previous 0); next cycle data_0=0xDEADBEEF.
//  T3 collision: wr0 r7=0x11, wr1 r7=0x22 same cycle -> r7=0x22; wr0 r30=0x55 ->
//     link unchanged; addr_0=31 -> data_0==pc_val.
//  T4 scoreboard: sb_set r9 -> next cycle busy_0=1 (addr_0=9); wr1 r9=0x99 -> busy
//     cleared next cycle, data=0x99; sb_set r9 + wr1 r9 same cycle -> busy stays 1.
//  T5 clear abort: pull rst_n low at clear cycle 10, release -> clear restarts at r0,
//     ready after a full 30 cycles; wr0 during clear -> r-target reads 0 afterwards.
//  T6 link: pc_val=0x400, pc_wr=1 -> addr_1=30 reads 0x400 next cycle, incl. during CLEAR.

Source files
------------

// File: rtl/zmips_regfile_sb.sv
// Register file with two async read ports, ALU/load write ports, load scoreboard and post-reset clear.
// Latency: reads and busy lookups are combinational; writes, scoreboard and link update on the rising edge.
// Backpressure: none; while the clear runs (ready=0), writes and scoreboard sets are dropped. Link capture is still honoured.
module zmips_regfile_sb #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  output logic [DATA_W-1:0] data_0,
  output logic [DATA_W-1:0] data_1,
  output logic              busy_0,
  output logic              busy_1,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  input  logic [DATA_W-1:0] pc_val,
  input  logic              pc_wr,
  output logic              ready
);

  localparam int NREGS = 1 << ADDR_W;
  localparam int NGPR  = NREGS - 2;

  // Special addresses: everything below LINK_A is a general-purpose register.
  localparam logic [ADDR_W-1:0] PC_A     = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] LINK_A   = ADDR_W'(NREGS - 2);
  localparam logic [ADDR_W-1:0] LAST_GPR = ADDR_W'(NREGS - 3);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   link_q, link_d;
  logic [NGPR-1:0]     busy_q, busy_d;
  logic [DATA_W-1:0]   gpr_q [NGPR];
  logic [DATA_W-1:0]   gpr_d [NGPR];

  logic run;
  assign run   = (state_q == ST_RUN);
  assign ready = ready_q;

  // Next-state: clear sequencer, GPR writes (port 1 wins), scoreboard (set wins), link capture.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    link_d    = link_q;
    busy_d    = busy_q;
    gpr_d     = gpr_q;

    if (pc_wr) begin
      link_d = pc_val;
    end

    case (state_q)
      ST_CLEAR: begin
        gpr_d[clr_idx_q] = '0;
        clr_idx_d        = clr_idx_q + ADDR_W'(1);
        if (clr_idx_q == LAST_GPR) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (wr0 && (wr0_addr < LINK_A)) begin
          gpr_d[wr0_addr] = wr0_data;
        end
        if (wr1 && (wr1_addr < LINK_A)) begin
          gpr_d[wr1_addr]  = wr1_data;
          busy_d[wr1_addr] = 1'b0;
        end
        // Set is applied after the load-return clear so a same-cycle reissue stays busy.
        if (sb_set && (sb_addr < LINK_A)) begin
          busy_d[sb_addr] = 1'b1;
        end
      end
    endcase

    ready_d = (state_d == ST_RUN);
  end

  // Control state, link and scoreboard; reset restarts the clear from GPR 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
      link_q    <= '0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
      link_q    <= link_d;
      busy_q    <= busy_d;
    end
  end

  // GPR storage has no reset; the clear sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    gpr_q <= gpr_d;
  end

  // Read port 0: PC and link are always live; GPRs read as zero until the clear completes.
  always_comb begin
    data_0 = '0;
    if (addr_0 == PC_A) begin
      data_0 = pc_val;
    end else if (addr_0 == LINK_A) begin
      data_0 = link_q;
    end else if (run) begin
      if ((BYPASS != 0) && wr1 && (wr1_addr == addr_0)) begin
        data_0 = wr1_data;
      end else if ((BYPASS != 0) && wr0 && (wr0_addr == addr_0)) begin
        data_0 = wr0_data;
      end else begin
        data_0 = gpr_q[addr_0];
      end
    end
    busy_0 = run && (addr_0 < LINK_A) && busy_q[addr_0];
  end

  // Read port 1: same selection as port 0.
  always_comb begin
    data_1 = '0;
    if (addr_1 == PC_A) begin
      data_1 = pc_val;
    end else if (addr_1 == LINK_A) begin
      data_1 = link_q;
    end else if (run) begin
      if ((BYPASS != 0) && wr1 && (wr1_addr == addr_1)) begin
        data_1 = wr1_data;
      end else if ((BYPASS != 0) && wr0 && (wr0_addr == addr_1)) begin
        data_1 = wr0_data;
      end else begin
        data_1 = gpr_q[addr_1];
      end
    end
    busy_1 = run && (addr_1 < LINK_A) && busy_q[addr_1];
  end

endmodule

// File: tb/tb_zmips_regfile_sb.sv
// Bench for zmips_regfile_sb: directed scenarios plus randomized traffic against a behavioural model.
// Latency: model expects combinational reads and edge-updated state.
// Backpressure: none; the model drops writes until the clear has run its 30 cycles.
module tb_zmips_regfile_sb;
  localparam int BYPASS = 1;
  localparam int NGPR   = 30;

  logic        clk;
  logic        rst_n;
  logic [4:0]  addr_0, addr_1;
  logic [31:0] data_0, data_1;
  logic        busy_0, busy_1;
  logic        wr0, wr1, sb_set, pc_wr;
  logic [4:0]  wr0_addr, wr1_addr, sb_addr;
  logic [31:0] wr0_data, wr1_data, pc_val;
  logic        ready;

  int n_checks = 0;
  int n_errs   = 0;

  zmips_regfile_sb #(
    .DATA_W(32), .ADDR_W(5), .BYPASS(BYPASS), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_0(addr_0), .addr_1(addr_1),
    .data_0(data_0), .data_1(data_1),
    .busy_0(busy_0), .busy_1(busy_1),
    .wr0(wr0), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1(wr1), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .pc_val(pc_val), .pc_wr(pc_wr),
    .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: register contents, link, busy bits and cycles of clear remaining.
  logic [31:0] m_gpr [NGPR];
  logic [31:0] m_link = '0;
  logic        m_busy [NGPR];
  int          m_clr_left = NGPR;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd31) return pc_val;
    if (a == 5'd30) return m_link;
    if (m_clr_left != 0) return 32'h0;
    if (BYPASS != 0 && wr1 && wr1_addr == a) return wr1_data;
    if (BYPASS != 0 && wr0 && wr0_addr == a) return wr0_data;
    return m_gpr[a];
  endfunction

  function automatic logic m_busy_rd(input logic [4:0] a);
    if (m_clr_left != 0 || a >= 5'd30) return 1'b0;
    return m_busy[a];
  endfunction

  // Model update on each edge; reset restarts the 30-cycle clear.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clr_left = NGPR;
      m_link     = '0;
      for (int i = 0; i < NGPR; i++) m_busy[i] = 1'b0;
    end else begin
      if (pc_wr) m_link = pc_val;
      if (m_clr_left == 0) begin
        if (wr0 && wr0_addr < 5'd30) m_gpr[wr0_addr] = wr0_data;
        if (wr1 && wr1_addr < 5'd30) begin
          m_gpr[wr1_addr]  = wr1_data;
          m_busy[wr1_addr] = 1'b0;
        end
        if (sb_set && sb_addr < 5'd30) m_busy[sb_addr] = 1'b1;
      end else begin
        m_clr_left--;
        if (m_clr_left == 0)
          for (int i = 0; i < NGPR; i++) m_gpr[i] = 32'h0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_data_0", data_0, m_read(addr_0));
    chk("model_data_1", data_1, m_read(addr_1));
    chk("model_busy_0", {31'h0, busy_0}, {31'h0, m_busy_rd(addr_0)});
    chk("model_busy_1", {31'h0, busy_1}, {31'h0, m_busy_rd(addr_1)});
    chk("model_ready",  {31'h0, ready},  {31'h0, (m_clr_left == 0)});
  end

  task automatic idle();
    wr0 = 1'b0; wr1 = 1'b0; sb_set = 1'b0; pc_wr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [4:0] raddr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(28, 31));
    return 5'($urandom_range(0, 9));
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    addr_0 = '0; addr_1 = '0;
    wr0_addr = '0; wr1_addr = '0; sb_addr = '0;
    wr0_data = '0; wr1_data = '0; pc_val = '0;

    // Reset and clear timing, with link capture and dropped writes during the clear.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    addr_1 = 5'd30;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      chk($sformatf("t1_ready_c%0d", i), {31'h0, ready}, {31'h0, (i == 31)});
      if (i == 7) chk("t6_link_in_clear", data_1, 32'h400);
      step();
      idle();
      if (i == 5) begin
        pc_val = 32'h400; pc_wr = 1'b1;
        wr0 = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h77;
        sb_set = 1'b1; sb_addr = 5'd4;
      end
    end
    idle();
    for (int r = 0; r < 30; r++) begin
      addr_0 = 5'(r);
      #1;
      chk($sformatf("t1_zero_r%0d", r), data_0, 32'h0);
      chk($sformatf("t1_busy_r%0d", r), {31'h0, busy_0}, 32'h0);
    end

    // Write with same-cycle read.
    step();
    wr0 = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF; addr_0 = 5'd5;
    @(negedge clk);
    chk("t2_bypass", data_0, (BYPASS != 0) ? 32'hDEADBEEF : 32'h0);
    step(); idle();
    @(negedge clk);
    chk("t2_stored", data_0, 32'hDEADBEEF);

    // Collision, ignored link write, live PC read.
    step();
    wr0 = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
    wr1 = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
    step(); idle();
    addr_0 = 5'd7;
    wr0 = 1'b1; wr0_addr = 5'd30; wr0_data = 32'h55; addr_1 = 5'd30;
    @(negedge clk);
    chk("t3_port1_wins", data_0, 32'h22);
    step(); idle();
    addr_0 = 5'd31; pc_val = 32'h1234;
    @(negedge clk);
    chk("t3_link_kept", data_1, 32'h400);
    chk("t3_pc_read", data_0, 32'h1234);

    // Scoreboard set, clear by load return, set-wins collision.
    step();
    sb_set = 1'b1; sb_addr = 5'd9; addr_0 = 5'd9;
    @(negedge clk);
    chk("t4_busy_not_bypassed", {31'h0, busy_0}, 32'h0);
    step(); idle();
    @(negedge clk);
    chk("t4_busy_set", {31'h0, busy_0}, 32'h1);
    step();
    wr1 = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h99;
    @(negedge clk);
    chk("t4_busy_held", {31'h0, busy_0}, 32'h1);
    step(); idle();
    @(negedge clk);
    chk("t4_busy_cleared", {31'h0, busy_0}, 32'h0);
    chk("t4_load_data", data_0, 32'h99);
    step();
    sb_set = 1'b1; sb_addr = 5'd9; wr1 = 1'b1; wr1_addr = 5'd9; wr1_data = 32'hAA;
    step(); idle();
    @(negedge clk);
    chk("t4_set_wins", {31'h0, busy_0}, 32'h1);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 599) == 0) begin
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      wr0 = ($urandom_range(0, 1) == 1); wr0_addr = raddr(); wr0_data = $urandom;
      wr1 = ($urandom_range(0, 2) == 0); wr1_addr = raddr(); wr1_data = $urandom;
      sb_set = ($urandom_range(0, 2) == 0); sb_addr = raddr();
      pc_wr = ($urandom_range(0, 7) == 0); pc_val = $urandom;
      addr_0 = raddr(); addr_1 = raddr();
    end

    // Reset during clear restarts it; writes during clear are dropped.
    step(); idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("t5_ready_pre_c%0d", i), {31'h0, ready}, 32'h0);
    end
    #2 rst_n = 1'b0;
    #6 rst_n = 1'b1;
    addr_0 = 5'd2;
    for (int j = 1; j <= 31; j++) begin
      @(negedge clk);
      chk($sformatf("t5_ready_c%0d", j), {31'h0, ready}, {31'h0, (j == 31)});
      step();
      idle();
      if (j == 25) begin
        wr0 = 1'b1; wr0_addr = 5'd2; wr0_data = 32'h5A5A;
      end
    end
    idle();
    @(negedge clk);
    chk("t5_write_dropped", data_0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
